// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Round-robin arbiter that shares one single-ported memory between two
// requesters, such as the I-side and D-side L1 controllers. The winning
// request's we/addr/wdata are latched. The memory enables are then driven for
// MEM_LAT cycles. A one-cycle done pulse follows, with read data registered
// into rdata. After each completed access, priority passes to the other port.
//
// Parameters:
//   WIDTH      data word width
//   ADDR_SIZE  word address width
//   MEM_LAT    memory access cycles (1..15; the counter is 4 bits)
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   req0/req1                level request, held until the matching done
//   we0/we1                  1 = write, 0 = read (sampled with the grant)
//   addr0/addr1              word address
//   wdata0/wdata1            write data
//   gnt0/gnt1                port owns the memory (ACCESS and DONE)
//   done0/done1              one-cycle completion pulse
//   rdata                    data of the last completed read
//   busy                     arbiter not idle
//   mem_addr/mem_wdata       latched address / write data to memory
//   mem_rd_en/mem_wr_en      memory enables, never both high
//   mem_rdata                memory read data, valid in the last ACCESS cycle
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int WIDTH     = 32,
    parameter int ADDR_SIZE = 10,
    parameter int MEM_LAT   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0,
    input  logic                 req1,
    input  logic                 we0,
    input  logic                 we1,
    input  logic [ADDR_SIZE-1:0] addr0,
    input  logic [ADDR_SIZE-1:0] addr1,
    input  logic [WIDTH-1:0]     wdata0,
    input  logic [WIDTH-1:0]     wdata1,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic                 done0,
    output logic                 done1,
    output logic [WIDTH-1:0]     rdata,
    output logic                 busy,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [WIDTH-1:0]     mem_wdata,
    output logic                 mem_rd_en,
    output logic                 mem_wr_en,
    input  logic [WIDTH-1:0]     mem_rdata
);

    localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   prio_q, prio_d;
    logic                   owner_q, owner_d;
    logic                   we_q, we_d;
    logic [ADDR_SIZE-1:0]   mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0]       mem_wdata_q, mem_wdata_d;
    logic [WIDTH-1:0]       rdata_q, rdata_d;
    logic                   gnt0_q, gnt0_d;
    logic                   gnt1_q, gnt1_d;
    logic                   done0_q, done0_d;
    logic                   done1_q, done1_d;
    logic                   rd_en_q, rd_en_d;
    logic                   wr_en_q, wr_en_d;
    logic                   busy_q, busy_d;

    // Arbitration: a lone requester wins outright; on contention prio decides.
    logic                   any_req;
    logic                   sel;
    logic                   sel_we;
    logic [ADDR_SIZE-1:0]   sel_addr;
    logic [WIDTH-1:0]       sel_wdata;

    always_comb begin
        any_req   = req0 | req1;
        sel       = (req0 && req1) ? prio_q : req1;
        sel_we    = sel ? we1 : we0;
        sel_addr  = sel ? addr1 : addr0;
        sel_wdata = sel ? wdata1 : wdata0;
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = ACCESS;
            ACCESS:  if (cnt_q == 4'd0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next values. Every output is a flop, so the values
    // computed here appear one cycle later; this is why the enables are set
    // on the grant edge and cleared on the last ACCESS edge.
    always_comb begin
        cnt_d       = cnt_q;
        prio_d      = prio_q;
        owner_d     = owner_q;
        we_d        = we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        done0_d     = 1'b0;
        done1_d     = 1'b0;
        rd_en_d     = 1'b0;
        wr_en_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    owner_d     = sel;
                    we_d        = sel_we;
                    mem_addr_d  = sel_addr;
                    mem_wdata_d = sel_wdata;
                    cnt_d       = CNT_LOAD;
                    gnt0_d      = !sel;
                    gnt1_d      = sel;
                    rd_en_d     = !sel_we;
                    wr_en_d     = sel_we;
                end
            end
            ACCESS: begin
                gnt0_d = !owner_q;
                gnt1_d = owner_q;
                if (cnt_q == 4'd0) begin
                    // Last access cycle: memory data is valid now.
                    if (!we_q) rdata_d = mem_rdata;
                    done0_d = !owner_q;
                    done1_d = owner_q;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                    rd_en_d = !we_q;
                    wr_en_d = we_q;
                end
            end
            DONE: begin
                prio_d = !owner_q;
            end
            default: begin
            end
        endcase
        busy_d = gnt0_d | gnt1_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= 4'd0;
            prio_q      <= 1'b0;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            prio_q      <= prio_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            done0_q     <= done0_d;
            done1_q     <= done1_d;
            rd_en_q     <= rd_en_d;
            wr_en_q     <= wr_en_d;
            busy_q      <= busy_d;
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign done0     = done0_q;
    assign done1     = done1_q;
    assign rdata     = rdata_q;
    assign busy      = busy_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_rd_en = rd_en_q;
    assign mem_wr_en = wr_en_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Self-checking bench for mem_port_arbiter. There are two instances:
//   dut   MEM_LAT = 4, the main instance and the one the reference model follows
//   dut1  MEM_LAT = 1, for the single-cycle access corner case
//
// The reference model describes each access as a time window. A request seen
// in an idle cycle t owns cycles t+1..t+L+1. The enables are high over
// t+1..t+L, done falls in t+L+1, and the read data is taken from memory in
// cycle t+L. It is evaluated every cycle alongside the directed checks.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;
    localparam int W = 32;
    localparam int A = 10;
    localparam int L = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         req0, req1, we0, we1;
    logic [A-1:0] addr0, addr1;
    logic [W-1:0] wdata0, wdata1, mem_rdata;
    logic         gnt0, gnt1, done0, done1, busy, mem_rd_en, mem_wr_en;
    logic [W-1:0] rdata, mem_wdata;
    logic [A-1:0] mem_addr;

    logic         b_req0;
    logic [A-1:0] b_addr0;
    logic [W-1:0] b_mrd;
    logic         b_gnt0, b_gnt1, b_done0, b_done1, b_busy, b_rd_en, b_wr_en;
    logic [W-1:0] b_rdata, b_mem_wdata;
    logic [A-1:0] b_mem_addr;

    mem_port_arbiter #(.WIDTH(W), .ADDR_SIZE(A), .MEM_LAT(L)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata(rdata), .busy(busy), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.WIDTH(W), .ADDR_SIZE(A), .MEM_LAT(1)) dut1 (
        .clk(clk), .rst(rst),
        .req0(b_req0), .req1(1'b0), .we0(1'b0), .we1(1'b0),
        .addr0(b_addr0), .addr1('0), .wdata0('0), .wdata1('0),
        .gnt0(b_gnt0), .gnt1(b_gnt1), .done0(b_done0), .done1(b_done1),
        .rdata(b_rdata), .busy(b_busy), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rd_en(b_rd_en), .mem_wr_en(b_wr_en), .mem_rdata(b_mrd)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    logic         m_active, m_owner, m_we, m_prio;
    logic [A-1:0] m_addr;
    logic [W-1:0] m_wdata, m_rdata;
    int           m_start;
    logic         e_gnt0, e_gnt1, e_done0, e_done1, e_rd, e_wr, e_busy;
    logic [A-1:0] e_addr;
    logic [W-1:0] e_wdata, e_rdata;

    task automatic model_reset();
        m_active = 1'b0; m_owner = 1'b0; m_we = 1'b0; m_prio = 1'b0;
        m_addr = '0; m_wdata = '0; m_rdata = '0; m_start = 0;
        e_gnt0 = 1'b0; e_gnt1 = 1'b0; e_done0 = 1'b0; e_done1 = 1'b0;
        e_rd = 1'b0; e_wr = 1'b0; e_busy = 1'b0;
        e_addr = '0; e_wdata = '0; e_rdata = '0;
    endtask

    // Consumes the inputs of cycle cyc; predicts the outputs of cycle cyc+1.
    task automatic model_step();
        int off;
        if (m_active) begin
            if (cyc == m_start + L && !m_we) m_rdata = mem_rdata;
            if (cyc == m_start + L + 1) begin
                m_prio   = !m_owner;
                m_active = 1'b0;
            end
        end else if (req0 || req1) begin
            m_owner  = (req0 && req1) ? m_prio : req1;
            m_we     = m_owner ? we1 : we0;
            m_addr   = m_owner ? addr1 : addr0;
            m_wdata  = m_owner ? wdata1 : wdata0;
            m_start  = cyc;
            m_active = 1'b1;
        end
        off     = cyc + 1 - m_start;
        e_gnt0  = m_active && !m_owner;
        e_gnt1  = m_active && m_owner;
        e_busy  = m_active;
        e_rd    = m_active && off <= L && !m_we;
        e_wr    = m_active && off <= L && m_we;
        e_done0 = m_active && off == L + 1 && !m_owner;
        e_done1 = m_active && off == L + 1 && m_owner;
        e_addr  = m_addr;
        e_wdata = m_wdata;
        e_rdata = m_rdata;
    endtask

    task automatic check_model();
        chk1("m_gnt0", gnt0, e_gnt0);
        chk1("m_gnt1", gnt1, e_gnt1);
        chk1("m_done0", done0, e_done0);
        chk1("m_done1", done1, e_done1);
        chk1("m_rd_en", mem_rd_en, e_rd);
        chk1("m_wr_en", mem_wr_en, e_wr);
        chk1("m_busy", busy, e_busy);
        chkw("m_mem_addr", 32'(mem_addr), 32'(e_addr));
        chkw("m_mem_wdata", mem_wdata, e_wdata);
        chkw("m_rdata", rdata, e_rdata);
        chk1("en_exclusive", mem_rd_en & mem_wr_en, 1'b0);
    endtask

    task automatic tick();
        if (!rst) model_reset();
        else      model_step();
        @(posedge clk);
        #1;
        cyc++;
        check_model();
    endtask

    task automatic wait_done(input logic port, output int at);
        at = -1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if ((port ? done1 : done0) === 1'b1) begin
                at = cyc;
                break;
            end
        end
        chk1("done_within_bound", at >= 0, 1'b1);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic         req0, we0;
        logic [A-1:0] addr0;
        logic [W-1:0] wdata0;
        logic         req1, we1;
        logic [A-1:0] addr1;
        logic [W-1:0] wdata1;
        logic [W-1:0] mrd;
        logic [6:0]   e_ctl;   // {gnt0,gnt1,done0,done1,rd_en,wr_en,busy}
        logic [A-1:0] e_addr;
        logic [W-1:0] e_wdata;
        logic [W-1:0] e_rdata;
    } vec_t;

    function automatic vec_t mk(input logic r0, input logic w0, input logic [A-1:0] a0,
                                input logic r1, input logic w1, input logic [A-1:0] a1,
                                input logic [W-1:0] d1, input logic [W-1:0] mrd,
                                input logic [6:0] ctl, input logic [A-1:0] ea,
                                input logic [W-1:0] ew, input logic [W-1:0] er);
        vec_t v;
        v.req0 = r0; v.we0 = w0; v.addr0 = a0; v.wdata0 = '0;
        v.req1 = r1; v.we1 = w1; v.addr1 = a1; v.wdata1 = d1;
        v.mrd = mrd; v.e_ctl = ctl; v.e_addr = ea; v.e_wdata = ew; v.e_rdata = er;
        return v;
    endfunction

    vec_t vt[14];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int at;
        int nd;
        int done_port[4];
        int done_cyc[4];
        int exp_port[4];
        logic [W-1:0] RD;
        logic [W-1:0] WD;
        logic [W-1:0] CF;
        RD = 32'hDEADBEEF;
        WD = 32'h12345678;
        CF = 32'hCAFEF00D;

        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; mem_rdata = '0;
        b_req0 = 1'b0; b_addr0 = '0; b_mrd = '0;
        model_reset();
        #3 rst = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        // Reset state
        chkw("reset_ctl", 32'({gnt0, gnt1, done0, done1, mem_rd_en, mem_wr_en, busy}), 32'd0);
        chkw("reset_rdata", rdata, 32'd0);
        chkw("reset_mem_addr", 32'(mem_addr), 32'd0);
        chkw("reset_mem_wdata", mem_wdata, 32'd0);
        chkw("reset1_ctl", 32'({b_gnt0, b_gnt1, b_done0, b_done1, b_rd_en, b_wr_en, b_busy}), 32'd0);
        rst = 1'b1;

        // Single read on port 0, then single write on port 1.
        // Row k: outputs expected in cycle k, then the inputs driven in cycle k.
        vt[0]  = mk(1, 0, 10'h005, 0, 0, 10'h000, '0, RD, 7'b0000000, 10'h000, '0, '0);
        vt[1]  = mk(1, 0, 10'h005, 0, 0, 10'h000, '0, RD, 7'b1000101, 10'h005, '0, '0);
        vt[2]  = mk(1, 0, 10'h005, 0, 0, 10'h000, '0, RD, 7'b1000101, 10'h005, '0, '0);
        vt[3]  = mk(1, 0, 10'h005, 0, 0, 10'h000, '0, RD, 7'b1000101, 10'h005, '0, '0);
        vt[4]  = mk(1, 0, 10'h005, 0, 0, 10'h000, '0, RD, 7'b1000101, 10'h005, '0, '0);
        vt[5]  = mk(0, 0, 10'h005, 0, 0, 10'h000, '0, RD, 7'b1010001, 10'h005, '0, RD);
        vt[6]  = mk(0, 0, 10'h000, 0, 0, 10'h000, '0, CF, 7'b0000000, 10'h005, '0, RD);
        vt[7]  = mk(0, 0, 10'h000, 1, 1, 10'h3FF, WD, CF, 7'b0000000, 10'h005, '0, RD);
        vt[8]  = mk(0, 0, 10'h000, 1, 1, 10'h3FF, WD, CF, 7'b0100011, 10'h3FF, WD, RD);
        vt[9]  = mk(0, 0, 10'h000, 1, 1, 10'h3FF, WD, CF, 7'b0100011, 10'h3FF, WD, RD);
        vt[10] = mk(0, 0, 10'h000, 1, 1, 10'h3FF, WD, CF, 7'b0100011, 10'h3FF, WD, RD);
        vt[11] = mk(0, 0, 10'h000, 1, 1, 10'h3FF, WD, CF, 7'b0100011, 10'h3FF, WD, RD);
        vt[12] = mk(0, 0, 10'h000, 0, 1, 10'h3FF, WD, CF, 7'b0101001, 10'h3FF, WD, RD);
        vt[13] = mk(0, 0, 10'h000, 0, 0, 10'h000, '0, CF, 7'b0000000, 10'h3FF, WD, RD);

        for (int k = 0; k < 14; k++) begin
            tick();
            chkw($sformatf("vec%0d_ctl", k),
                 32'({gnt0, gnt1, done0, done1, mem_rd_en, mem_wr_en, busy}), 32'(vt[k].e_ctl));
            chkw($sformatf("vec%0d_mem_addr", k), 32'(mem_addr), 32'(vt[k].e_addr));
            chkw($sformatf("vec%0d_mem_wdata", k), mem_wdata, vt[k].e_wdata);
            chkw($sformatf("vec%0d_rdata", k), rdata, vt[k].e_rdata);
            req0 = vt[k].req0; we0 = vt[k].we0; addr0 = vt[k].addr0; wdata0 = vt[k].wdata0;
            req1 = vt[k].req1; we1 = vt[k].we1; addr1 = vt[k].addr1; wdata1 = vt[k].wdata1;
            mem_rdata = vt[k].mrd;
        end

        // MEM_LAT = 1: enable for one cycle, data captured from that cycle
        tick();
        b_req0 = 1'b1; b_addr0 = 10'h02A; b_mrd = 32'h11111111;
        tick();
        chk1("lat1_rd_c1", b_rd_en, 1'b1);
        chk1("lat1_gnt_c1", b_gnt0, 1'b1);
        chk1("lat1_done_c1", b_done0, 1'b0);
        chkw("lat1_addr_c1", 32'(b_mem_addr), 32'h2A);
        b_mrd = 32'h0BADF00D;
        tick();
        chk1("lat1_rd_c2", b_rd_en, 1'b0);
        chk1("lat1_done_c2", b_done0, 1'b1);
        chk1("lat1_gnt_c2", b_gnt0, 1'b1);
        chkw("lat1_rdata_c2", b_rdata, 32'h0BADF00D);
        b_req0 = 1'b0; b_mrd = 32'h22222222;
        tick();
        chk1("lat1_busy_c3", b_busy, 1'b0);
        chk1("lat1_done_c3", b_done0, 1'b0);
        chkw("lat1_rdata_c3", b_rdata, 32'h0BADF00D);
        chkw("lat1_other", 32'({b_gnt1, b_done1, b_wr_en}), 32'd0);
        chkw("lat1_wdata", b_mem_wdata, 32'd0);

        // Contention: both ports request continuously for four accesses
        req0 = 1'b1; we0 = 1'b0; addr0 = 10'h010;
        req1 = 1'b1; we1 = 1'b1; addr1 = 10'h020; wdata1 = 32'h5555AAAA;
        exp_port = '{0, 1, 0, 1};
        done_port = '{-1, -1, -1, -1};
        done_cyc  = '{-1, -1, -1, -1};
        nd = 0;
        for (int k = 0; k < 60 && nd < 4; k++) begin
            mem_rdata = $urandom;
            tick();
            if (done0 === 1'b1) begin
                done_port[nd] = 0; done_cyc[nd] = cyc; nd++;
            end else if (done1 === 1'b1) begin
                done_port[nd] = 1; done_cyc[nd] = cyc; nd++;
            end
            if (nd == 4) begin
                req0 = 1'b0; req1 = 1'b0;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        for (int i = 0; i < 4; i++)
            chkw($sformatf("rr_order%0d", i), 32'(done_port[i]), 32'(exp_port[i]));
        for (int i = 1; i < 4; i++)
            chkw($sformatf("rr_gap%0d", i), 32'(done_cyc[i] - done_cyc[i-1]), 32'd6);
        tick();

        // Request withdrawn during ACCESS, with port 1 pending
        req0 = 1'b1; we0 = 1'b0; addr0 = 10'h033;
        tick();
        tick();
        req0 = 1'b0; req1 = 1'b1; we1 = 1'b0; addr1 = 10'h044;
        tick();
        chk1("wd_rd_c3", mem_rd_en, 1'b1);
        tick();
        chk1("wd_rd_c4", mem_rd_en, 1'b1);
        chk1("wd_gnt0_c4", gnt0, 1'b1);
        tick();
        chk1("wd_done0_c5", done0, 1'b1);
        tick();
        chk1("wd_busy_c6", busy, 1'b0);
        tick();
        chk1("wd_gnt1_c7", gnt1, 1'b1);
        wait_done(1'b1, at);
        req1 = 1'b0;
        tick();

        // Asynchronous reset in the middle of a port-1 read
        req0 = 1'b1; we0 = 1'b0; addr0 = 10'h011; mem_rdata = 32'hA5A5A5A5;
        wait_done(1'b0, at);
        req0 = 1'b0; req1 = 1'b1; we1 = 1'b0; addr1 = 10'h055;
        tick();
        tick();
        tick();
        chk1("rst_pre_gnt1", gnt1, 1'b1);
        #2 rst = 1'b0;
        #1;
        chkw("rst_async_ctl", 32'({gnt0, gnt1, done0, done1, mem_rd_en, mem_wr_en, busy}), 32'd0);
        chkw("rst_async_rdata", rdata, 32'd0);
        chkw("rst_async_mem_addr", 32'(mem_addr), 32'd0);
        chkw("rst_async_mem_wdata", mem_wdata, 32'd0);
        model_reset();
        req0 = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        chk1("rst_after_gnt0", gnt0, 1'b1);
        chk1("rst_after_gnt1", gnt1, 1'b0);
        wait_done(1'b0, at);
        req0 = 1'b0; req1 = 1'b0;
        tick();
        tick();

        // Randomized traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            if (req0) begin
                if (e_done0 && $urandom_range(3) != 0) req0 = 1'b0;
                else if (e_gnt0 && (e_rd || e_wr) && $urandom_range(19) == 0) req0 = 1'b0;
            end else if ($urandom_range(2) == 0) begin
                req0 = 1'b1;
            end
            if (req1) begin
                if (e_done1 && $urandom_range(3) != 0) req1 = 1'b0;
                else if (e_gnt1 && (e_rd || e_wr) && $urandom_range(19) == 0) req1 = 1'b0;
            end else if ($urandom_range(2) == 0) begin
                req1 = 1'b1;
            end
            we0 = 1'($urandom_range(1)); we1 = 1'($urandom_range(1));
            addr0 = A'($urandom); addr1 = A'($urandom);
            wdata0 = $urandom; wdata1 = $urandom;
            mem_rdata = $urandom;
            tick();
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (12) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-port round-robin arbiter that shares the single-ported main memory between two cache controllers, e.g. the instruction-side and data-side L1 controllers. Each requester issues a read or write with a level request. The arbiter grants one requester at a time and drives the memory read/write enables for a fixed access latency. It returns read data with a one-cycle done pulse, which lets the write-through caches stall cleanly on a shared memory.

## Interface
Parameters:
- WIDTH, 32, data word width
- ADDR_SIZE, 10, word address width
- MEM_LAT, 4, memory access cycles; legal range 1..15

Ports:
- clk  in  1  single clock; all state changes on posedge
- rst  in  1  asynchronous, active-low reset
- req0 / req1  in  1  access request; held high until the matching done pulse
- we0 / we1  in  1  1 = write, 0 = read; sampled with the grant
- addr0 / addr1  in  ADDR_SIZE  word address
- wdata0 / wdata1  in  WIDTH  write data
- gnt0 / gnt1  out  1  requester owns memory; high in ACCESS and DONE
- done0 / done1  out  1  one-cycle completion pulse
- rdata  out  WIDTH  read data from the last completed read
- busy  out  1  state != IDLE
- mem_addr  out  ADDR_SIZE  latched address to memory
- mem_wdata  out  WIDTH  latched write data to memory
- mem_rd_en / mem_wr_en  out  1  memory enables; at most one high
- mem_rdata  in  WIDTH  memory read data; valid in the last ACCESS cycle

## Operation
- State machine has three states: IDLE, ACCESS and DONE. There is a 4-bit down-counter `cnt` and a 1-bit priority pointer `prio` (0 = port 0 preferred).
- IDLE, no requests: stay in IDLE.
- IDLE, only one request pending: grant that port.
- IDLE, both requests pending: grant port `prio`.
- On grant:
  - Latch owner, we, addr and wdata into mem_addr, mem_wdata and the internal we.
  - Load `cnt` = MEM_LAT-1.
  - Go to ACCESS.
- ACCESS:
  - mem_rd_en = !we_latched and mem_wr_en = we_latched, both registered and held constant throughout ACCESS.
  - Decrement `cnt` each cycle.
  - At `cnt` == 0: on a read, register mem_rdata into rdata; go to DONE.
- DONE:
  - done<owner> = 1 for exactly one cycle; gnt<owner> stays high.
  - Both enables are low.
  - `prio` is set to the other port; go to IDLE.
- rdata holds its value across writes and idle cycles. Only a completed read updates it.
- A requester dropping req during ACCESS does not abort the access. The access completes, done still pulses, and the done is ignorable.
- A requester that keeps req high after its done is re-arbitrated in the next IDLE cycle. Because of `prio`, the other port wins if it is requesting.
- we/addr/wdata changes after the grant have no effect on the access in flight.

## Timing
- Reset (async assert, any state):
  - State goes to IDLE; `prio` = 0; `cnt` = 0; rdata = 0; mem_addr = 0; mem_wdata = 0.
  - All 1-bit outputs are 0 immediately.
  - No done is issued for an aborted access.
- Request sampled in IDLE in cycle 0:
  - Enables are high in cycles 1..MEM_LAT.
  - done is high in cycle MEM_LAT+1.
  - IDLE resumes in cycle MEM_LAT+2.
- Back-to-back throughput: one access per MEM_LAT+2 cycles.
- rdata is valid in the done cycle and stays valid until the next read completes.
- gnt is high in cycles 1..MEM_LAT+1; busy equals the OR of gnt0 and gnt1.
- All outputs are registered; there is no combinational path from req to any output.

## Test plan
- Reset behaviour:
  - Stimulus: assert rst low mid-ACCESS on a port-1 read, with MEM_LAT=4.
  - Required: all enables, gnt, done and busy go to 0 asynchronously; rdata = 0.
  - After release with req0=1: port 0 is granted first (`prio` = 0).
- Single read:
  - Stimulus: req0=1, we0=0, addr0=0x05, memory returns 0xDEADBEEF.
  - Required: mem_rd_en high cycles 1-4, mem_addr=0x05, done0 in cycle 5 with rdata=0xDEADBEEF, busy low in cycle 6.
- Single write:
  - Stimulus: req1=1, we1=1, addr1=0x3FF, wdata1=0x12345678.
  - Required: mem_wr_en high cycles 1-4 with mem_wdata=0x12345678; done1 in cycle 5; rdata unchanged from the previous read.
- Contention and fairness:
  - Stimulus: req0 and req1 held high continuously for four transactions.
  - Required: grant order 0,1,0,1; each done is 6 cycles apart; mem_rd_en and mem_wr_en are never high together.
- Request withdrawn:
  - Stimulus: req0 drops in cycle 2 of an ACCESS.
  - Required: enables are still high through cycle 4 and done0 still pulses in cycle 5.
  - With req1 pending, port 1 is granted next.
- MEM_LAT=1 corner:
  - Stimulus: MEM_LAT=1, single read.
  - Required: mem_rd_en high in cycle 1 only, done in cycle 2, and rdata captured from cycle 1.
